// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: input capture, unpack, align, add/normalise, round/pack.
// Subnormal operands read as signed zero; results below the normal range flush to zero.
module fp_addsub_pipe #(
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  out_valid,
    output logic                  overflow,
    output logic                  invalid
);
    localparam int EW = EXP_WIDTH;
    localparam int MW = MAN_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int FW = MW + 4;
    localparam int XW = EW + 2;
    localparam logic [EW-1:0] EXP_ONES = '1;
    localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EW) - 1);
    localparam logic [DW-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

    // Valid semantics: an operation is accepted on any rising edge with en=1 and in_valid=1;
    // its valid bit walks one stage per enabled edge and lands in out_valid four enabled edges later.

    function automatic int lzc(input logic [FW-1:0] v);
        int n;
        n = FW;
        for (int i = 0; i < FW; i++) begin
            if (v[i]) n = FW - 1 - i;
        end
        return n;
    endfunction

    logic          v0_q, op0_q;
    logic [DW-1:0] a0_q, b0_q;

    logic          v1_q, sx1_q, sub1_q, sp1_q, inv1_q;
    logic          sx1_d, sub1_d, sp1_d, inv1_d;
    logic [EW-1:0] ex1_q, ex1_d, d1_q, d1_d;
    logic [MW:0]   sigx1_q, sigx1_d, sigy1_q, sigy1_d;
    logic [DW-1:0] spr1_q, spr1_d;

    logic          v2_q, sx2_q, sub2_q, sp2_q, inv2_q;
    logic [EW-1:0] ex2_q;
    logic [MW:0]   sigx2_q;
    logic [FW-1:0] ya2_q, ya2_d;
    logic [DW-1:0] spr2_q;

    logic                 v3_q, sx3_q, z3_q, z3_d, sp3_q, inv3_q;
    logic signed [XW-1:0] e3_q, e3_d;
    logic [FW-1:0]        m3_q, m3_d;
    logic [DW-1:0]        spr3_q;

    logic          ov_q, ovf_q, inv_q, ovf_d, inv_d;
    logic [DW-1:0] result_q, res_d;

    // Unpack: classify, apply op, order by magnitude, precompute special result.
    logic [EW-1:0] ea, eb;
    logic [DW-2:0] ma, mb;
    logic          sa, sb, za, zb, ia, ib, na, nb, swap;
    always_comb begin
        ea = a0_q[DW-2 -: EW];
        eb = b0_q[DW-2 -: EW];
        sa = a0_q[DW-1];
        sb = b0_q[DW-1] ^ op0_q;
        za = (ea == '0);
        zb = (eb == '0);
        ia = (ea == EXP_ONES) && (a0_q[MW-1:0] == '0);
        ib = (eb == EXP_ONES) && (b0_q[MW-1:0] == '0);
        na = (ea == EXP_ONES) && (a0_q[MW-1:0] != '0);
        nb = (eb == EXP_ONES) && (b0_q[MW-1:0] != '0);
        ma = za ? '0 : a0_q[DW-2:0];
        mb = zb ? '0 : b0_q[DW-2:0];
        swap = (mb > ma);
        sx1_d   = swap ? sb : sa;
        sub1_d  = sa ^ sb;
        ex1_d   = swap ? eb : ea;
        sigx1_d = swap ? {~zb, mb[MW-1:0]} : {~za, ma[MW-1:0]};
        sigy1_d = swap ? {~za, ma[MW-1:0]} : {~zb, mb[MW-1:0]};
        d1_d    = swap ? (eb - ea) : (ea - eb);
        inv1_d  = na | nb | (ia & ib & (sa != sb));
        sp1_d   = inv1_d | ia | ib | (za & zb);
        if (inv1_d)  spr1_d = QNAN;
        else if (ia) spr1_d = {sa, EXP_ONES, {MW{1'b0}}};
        else if (ib) spr1_d = {sb, EXP_ONES, {MW{1'b0}}};
        else         spr1_d = {sa & sb, {(DW-1){1'b0}}};
    end

    // Align: everything shifted past the field collapses into the sticky bit.
    logic [FW-1:0]   field;
    logic [2*FW-1:0] ext;
    always_comb begin
        field = {sigy1_q, 3'b000};
        ext   = {field, {FW{1'b0}}} >> d1_q;
        if (32'(d1_q) >= FW) ya2_d = {{(FW-1){1'b0}}, |field};
        else                 ya2_d = ext[2*FW-1:FW] | {{(FW-1){1'b0}}, |ext[FW-1:0]};
    end

    // Add/subtract and normalise; x >= y in magnitude so the difference is never negative.
    logic [FW:0] xf, yf, sum;
    int          lz;
    always_comb begin
        xf   = {1'b0, sigx2_q, 3'b000};
        yf   = {1'b0, ya2_q};
        sum  = sub2_q ? (xf - yf) : (xf + yf);
        lz   = lzc(sum[FW-1:0]);
        z3_d = (sum == '0);
        if (sum[FW]) begin
            m3_d = {sum[FW:2], sum[1] | sum[0]};
            e3_d = {2'b00, ex2_q} + XW'(1);
        end else begin
            m3_d = sum[FW-1:0] << lz;
            e3_d = {2'b00, ex2_q} - XW'(lz);
        end
    end

    // Round to nearest even, renormalise on carry, then saturate or flush.
    logic                 rup;
    logic [MW+1:0]        sig_r;
    logic signed [XW-1:0] e4;
    logic [MW-1:0]        frac;
    always_comb begin
        rup   = m3_q[2] & (m3_q[1] | m3_q[0] | m3_q[3]);
        sig_r = {1'b0, m3_q[FW-1:3]} + {{(MW+1){1'b0}}, rup};
        e4    = sig_r[MW+1] ? (e3_q + XW'(1)) : e3_q;
        frac  = sig_r[MW+1] ? sig_r[MW:1] : sig_r[MW-1:0];
        ovf_d = 1'b0;
        inv_d = inv3_q;
        if (sp3_q)                        res_d = spr3_q;
        else if (z3_q)                    res_d = '0;
        else if (e4 >= EXP_INF) begin
            res_d = {sx3_q, EXP_ONES, {MW{1'b0}}};
            ovf_d = 1'b1;
        end
        else if (e4[XW-1] || e4 == '0)    res_d = {sx3_q, {(DW-1){1'b0}}};
        else                              res_d = {sx3_q, e4[EW-1:0], frac};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v0_q <= 1'b0; op0_q <= 1'b0; a0_q <= '0; b0_q <= '0;
            v1_q <= 1'b0; sx1_q <= 1'b0; sub1_q <= 1'b0; sp1_q <= 1'b0; inv1_q <= 1'b0;
            ex1_q <= '0; d1_q <= '0; sigx1_q <= '0; sigy1_q <= '0; spr1_q <= '0;
            v2_q <= 1'b0; sx2_q <= 1'b0; sub2_q <= 1'b0; sp2_q <= 1'b0; inv2_q <= 1'b0;
            ex2_q <= '0; sigx2_q <= '0; ya2_q <= '0; spr2_q <= '0;
            v3_q <= 1'b0; sx3_q <= 1'b0; z3_q <= 1'b0; sp3_q <= 1'b0; inv3_q <= 1'b0;
            e3_q <= '0; m3_q <= '0; spr3_q <= '0;
            ov_q <= 1'b0; ovf_q <= 1'b0; inv_q <= 1'b0; result_q <= '0;
        end else if (en) begin
            v0_q <= in_valid; op0_q <= op; a0_q <= a; b0_q <= b;
            v1_q <= v0_q; sx1_q <= sx1_d; sub1_q <= sub1_d; sp1_q <= sp1_d; inv1_q <= inv1_d;
            ex1_q <= ex1_d; d1_q <= d1_d; sigx1_q <= sigx1_d; sigy1_q <= sigy1_d; spr1_q <= spr1_d;
            v2_q <= v1_q; sx2_q <= sx1_q; sub2_q <= sub1_q; sp2_q <= sp1_q; inv2_q <= inv1_q;
            ex2_q <= ex1_q; sigx2_q <= sigx1_q; ya2_q <= ya2_d; spr2_q <= spr1_q;
            v3_q <= v2_q; sx3_q <= sx2_q; z3_q <= z3_d; sp3_q <= sp2_q; inv3_q <= inv2_q;
            e3_q <= e3_d; m3_q <= m3_d; spr3_q <= spr2_q;
            ov_q <= v3_q;
            // Bubbles leave the last result and flags in place.
            if (v3_q) begin
                result_q <= res_d;
                ovf_q    <= ovf_d;
                inv_q    <= inv_d;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = ov_q;
    assign overflow  = ovf_q;
    assign invalid   = inv_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary16): hand-computed vector table plus stall, bubble and reset sequences.
module tb_fp_addsub_pipe;
    localparam int DW = 16;
    localparam int W  = 18;   // {overflow, invalid, result}
    localparam int NV = 25;

    logic          clk = 1'b0;
    logic          reset, en, in_valid, op;
    logic [DW-1:0] a, b, result;
    logic          out_valid, overflow, invalid;

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .a(a), .b(b), .result(result), .out_valid(out_valid),
        .overflow(overflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
        logic        ovf;
        logic        inv;
    } vec_t;
    vec_t vt [NV];

    logic [W-1:0] exp_q[$];
    logic [3:0]   m_v;
    logic         m_ov;
    logic [W-1:0] m_cur;
    logic         sb_under = 1'b0;
    logic         mon_on = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-output timing: valid bits advance on enabled edges; values come from the scoreboard.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_v   <= '0;
            m_ov  <= 1'b0;
            m_cur <= '0;
            exp_q.delete();
        end else if (en) begin
            m_v  <= {m_v[2:0], in_valid};
            m_ov <= m_v[3];
            if (m_v[3]) begin
                if (exp_q.size() == 0) begin
                    sb_under <= 1'b1;
                    m_cur    <= '1;
                end else begin
                    m_cur <= exp_q.pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("out_valid", W'(out_valid), W'(m_ov));
            chk("result", W'(result), W'(m_cur[15:0]));
            chk("flags", W'({overflow, invalid}), W'(m_cur[17:16]));
        end
    end

    task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic top, input logic [W-1:0] e);
        in_valid = v;
        a = ta;
        b = tbv;
        op = top;
        if (v && en && reset) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive_vec(input int i);
        drive(1'b1, vt[i].a, vt[i].b, vt[i].op, {vt[i].ovf, vt[i].inv, vt[i].res});
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h7C00, 16'h7C00, 1'b1, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{16'h4200, 16'hC600, 1'b0, 16'hC200, 1'b0, 1'b0};
        vt[1]  = '{16'h4200, 16'hC600, 1'b1, 16'h4880, 1'b0, 1'b0};
        vt[2]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0};
        vt[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0};
        vt[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0};
        vt[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0};
        vt[6]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b1};
        vt[7]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0};
        vt[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0};
        vt[9]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0};
        vt[10] = '{16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 1'b0, 1'b0};
        vt[11] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1};
        vt[12] = '{16'hFC01, 16'h0000, 1'b1, 16'h7E00, 1'b0, 1'b1};
        vt[13] = '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 1'b0, 1'b0};
        vt[14] = '{16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 1'b0, 1'b0};
        vt[15] = '{16'h8401, 16'h8400, 1'b1, 16'h8000, 1'b0, 1'b0};
        vt[16] = '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 1'b1, 1'b0};
        vt[17] = '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 1'b0, 1'b0};
        vt[18] = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 1'b0, 1'b0};
        vt[19] = '{16'h3C00, 16'h1001, 1'b1, 16'h3BFF, 1'b0, 1'b0};
        vt[20] = '{16'h3C01, 16'h0800, 1'b0, 16'h3C01, 1'b0, 1'b0};
        vt[21] = '{16'h0000, 16'hBC00, 1'b1, 16'h3C00, 1'b0, 1'b0};
        vt[22] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0};
        vt[23] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[24] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0};

        reset = 1'b1; en = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
        #3 reset = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;

        // Back-to-back table stream.
        for (int i = 0; i < NV; i++) drive_vec(i);
        bubble(6);

        // Stall after the 2nd accepted operation, then a second stall while results drain.
        drive_vec(2);
        drive_vec(3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'b1, 16'h3C00, 16'h3C00, 1'b1, '0);
        en = 1'b1;
        drive_vec(4);
        bubble(2);
        en = 1'b0;
        for (int k = 0; k < 3; k++) drive(1'b1, 16'h7BFF, 16'h7BFF, 1'b0, '0);
        en = 1'b1;
        bubble(6);

        // Interleaved bubbles.
        drive_vec(5);
        bubble(1);
        drive_vec(6);
        drive_vec(7);
        bubble(2);
        drive_vec(9);
        bubble(6);

        // Asynchronous reset between edges with operations in flight.
        for (int k = 0; k < 6; k++) drive_vec(2);
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_result", W'(result), '0);
        chk("rst_flags", W'({overflow, invalid}), '0);
        @(negedge clk);
        drive(1'b1, 16'h3C00, 16'h3C00, 1'b0, '0);
        drive(1'b1, 16'h3C00, 16'h3C00, 1'b0, '0);
        reset = 1'b1;
        bubble(6);
        drive_vec(0);
        drive_vec(1);
        bubble(6);

        chk("sb_empty", W'(exp_q.size()), '0);
        chk("sb_underflow", W'(sb_under), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
